uart_receiver: RTL

//   Receive side of the on-chip UART (8N1, LSB first). Deserialises serial_in into bytes,

---
 rtl/uart_receiver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive path with one-entry ready/valid output buffer
//
// Purpose:
//   Deserialises an asynchronous 8N1 (LSB-first) serial line into bytes.
//   Every bit is sampled at its centre and the stop bit is checked.
//   Each good byte is presented through a one-entry ready/valid buffer.
//
// Ports:
//   clk             in   1  system clock, all state on posedge
//   reset           in   1  synchronous, active-high reset
//   serial_in       in   1  asynchronous UART line, idles high
//   data_out        out  8  received byte, stable while data_out_valid=1
//   data_out_valid  out  1  buffer holds an unread byte
//   data_out_ready  in   1  consumer takes the byte when valid&&ready at posedge
//   framing_error   out  1  one-cycle pulse: stop bit sampled 0, byte discarded
//   overrun         out  1  one-cycle pulse: byte completed while buffer full, new byte dropped

module uart_receiver #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
  localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            sync_q, rx_q;

  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            fe_q, fe_d;
  logic            ov_q, ov_d;

  logic            deliver;
  logic            frame_bad;

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign framing_error  = fe_q;
  assign overrun        = ov_q;

  // Receive FSM and bit timing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    frame_bad = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_q) state_d = START;
      end
      START: begin
        // Half a bit into the start bit: a high line here was only a glitch.
        if (cnt_q == SAMPLE_LAST) begin
          if (rx_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end
      end
      DATA: begin
        // Counter is centre-aligned after START, so each full period lands mid-bit.
        if (cnt_q == SYMBOL_LAST) begin
          shift_d   = {rx_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == SYMBOL_LAST) begin
          if (rx_q) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        // A line held low must go high before a new start edge is accepted.
        if (rx_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // One-entry output buffer
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = frame_bad;
    ov_d    = 1'b0;

    if (deliver) begin
      // A handshake in the same cycle frees the slot for the new byte.
      if (!valid_q || data_out_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end else if (valid_q && data_out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= 1'b1;
      rx_q      <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      sync_q    <= serial_in;
      rx_q      <= sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

endmodule
